stream_mac_ctrl: RTL and testbench



---
 rtl/stream_ctrl_pkg.sv | 20 ++
 rtl/lane_delay_line.sv | 40 ++++
 rtl/stream_mac_ctrl.sv | 148 ++++++++++++++
 tb/tb_stream_mac_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_ctrl_pkg.sv
// Shared definitions for the streamline MAC lane controller: FSM state
// encoding and a helper that sizes counters from their maximum value.
package stream_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_e;

   // Bits needed to hold values 0..maxVal, never fewer than one bit.
   function automatic int cntWidth(input int maxVal);
      if (maxVal < 1) begin
         return 1;
      end
      return $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/lane_delay_line.sv
// Fixed-depth shift register carrying a lane's {en, clr} pair so that lane k
// replays lane 0's schedule DEPTH cycles later. The whole line freezes while
// stalled, keeping every lane aligned to the same schedule time. With DEPTH=0
// it is a plain wire.
module lane_delay_line #(
   parameter int DEPTH = 0
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_stall,
   input  logic [1:0] i_data,
   output logic [1:0] o_data
);

   if (DEPTH == 0) begin : g_wire
      logic w_unused;

      assign w_unused = i_clk ^ i_rstn ^ i_stall;
      assign o_data   = i_data;
   end else begin : g_shift
      logic [1:0] r_stage [DEPTH];

      // Shift one stage per non-stalled cycle; reset empties the whole line.
      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_stage[i] <= 2'b00;
            end
         end else if (!i_stall) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
               r_stage[i] <= r_stage[i-1];
            end
         end
      end

      assign o_data = r_stage[DEPTH-1];
   end

endmodule

// File: rtl/stream_mac_ctrl.sv
// Controller for a bank of NUM_LANE MAC accumulators. Lane 0's enable/clear
// schedule is generated by a registered FSM. Each further lane replays that
// schedule through its own delay line, shifted by k*SKEW cycles. Multiple
// passes run back to back. Stall freezes the whole schedule and masks the lane
// outputs for as long as it is held.
module stream_mac_ctrl
   import stream_ctrl_pkg::*;
#(
   parameter int NUM_LANE = 2,
   parameter int MAC_LEN  = 53,
   parameter int SKEW     = 0,
   parameter int PASS_W   = 8
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                start_i,
   input  logic [PASS_W-1:0]   num_pass_i,
   input  logic                stall_i,
   output logic [NUM_LANE-1:0] local_en_o,
   output logic [NUM_LANE-1:0] clear_local_o,
   output logic [PASS_W-1:0]   pass_idx_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int DRAIN_LEN = (NUM_LANE - 1) * SKEW;
   localparam int MAC_W     = cntWidth(MAC_LEN);
   localparam int DRAIN_W   = cntWidth(DRAIN_LEN);

   localparam logic [MAC_W-1:0]   MAC_ONE    = MAC_W'(1);
   localparam logic [MAC_W-1:0]   MAC_LAST   = MAC_W'(MAC_LEN);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);
   localparam logic [PASS_W-1:0]  PASS_ONE   = PASS_W'(1);

   ctrl_state_e        r_state;
   logic [MAC_W-1:0]   r_macCnt;
   logic [DRAIN_W-1:0] r_drainCnt;
   logic [PASS_W-1:0]  r_numPass;
   logic [PASS_W-1:0]  r_passIdx;
   logic               r_en0;
   logic               r_clr0;
   logic               r_busy;
   logic               r_done;

   logic               w_lastPass;
   logic [1:0]         w_laneBits [NUM_LANE];

   // The pass whose clear is being issued is the final one.
   assign w_lastPass = (r_passIdx == (r_numPass - PASS_ONE));

   // Lane-0 schedule, pass sequencing and drain tracking. Lane-0 en/clr are
   // registered here one cycle ahead of their use. A zero pass count is
   // promoted to a single pass when latched.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state    <= ST_IDLE;
         r_macCnt   <= '0;
         r_drainCnt <= '0;
         r_numPass  <= '0;
         r_passIdx  <= '0;
         r_en0      <= 1'b0;
         r_clr0     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start_i) begin
                  r_state    <= ST_RUN;
                  r_busy     <= 1'b1;
                  r_en0      <= 1'b1;
                  r_clr0     <= 1'b0;
                  r_macCnt   <= MAC_ONE;
                  r_drainCnt <= '0;
                  r_passIdx  <= '0;
                  r_numPass  <= (num_pass_i == '0) ? PASS_ONE : num_pass_i;
               end
            end
            ST_RUN: begin
               if (!stall_i) begin
                  if (r_clr0) begin
                     r_clr0    <= 1'b0;
                     r_passIdx <= r_passIdx + PASS_ONE;
                     if (w_lastPass) begin
                        r_en0      <= 1'b0;
                        r_drainCnt <= '0;
                        if (DRAIN_LEN == 0) begin
                           r_state <= ST_DONE;
                           r_done  <= 1'b1;
                        end else begin
                           r_state <= ST_DRAIN;
                        end
                     end else begin
                        r_en0    <= 1'b1;
                        r_macCnt <= MAC_ONE;
                     end
                  end else if (r_macCnt == MAC_LAST) begin
                     r_en0  <= 1'b0;
                     r_clr0 <= 1'b1;
                  end else begin
                     r_macCnt <= r_macCnt + MAC_ONE;
                  end
               end
            end
            ST_DRAIN: begin
               if (!stall_i) begin
                  if (r_drainCnt == DRAIN_LAST) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_drainCnt <= r_drainCnt + DRAIN_ONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
      lane_delay_line #(
         .DEPTH(k * SKEW)
      ) u_line (
         .i_clk  (clk_i),
         .i_rstn (rstn_i),
         .i_stall(stall_i),
         .i_data ({r_en0, r_clr0}),
         .o_data (w_laneBits[k])
      );

      assign local_en_o[k]    = w_laneBits[k][1] & ~stall_i;
      assign clear_local_o[k] = w_laneBits[k][0] & ~stall_i;
   end

   assign pass_idx_o = r_passIdx;
   assign busy_o     = r_busy;
   assign done_o     = r_done;

endmodule

// File: tb/tb_stream_mac_ctrl.sv
// Self-checking bench for stream_mac_ctrl. Two instances are used: defaults
// (2 lanes, MAC_LEN 53, no skew) and a skewed 4-lane, MAC_LEN 4 build. The
// expected outputs come from a schedule-time model. Each lane is a periodic
// en/clr pattern over "schedule time", which advances only on non-stalled
// cycles.
module tb_stream_mac_ctrl;

   logic       clk = 1'b0;
   logic       rstn;

   logic       startA, stallA;
   logic [7:0] numPassA;
   logic [1:0] enA, clrA;
   logic [7:0] passA;
   logic       busyA, doneA;

   logic       startB, stallB;
   logic [7:0] numPassB;
   logic [3:0] enB, clrB;
   logic [7:0] passB;
   logic       busyB, doneB;

   int vectors = 0;
   int miscompares = 0;
   int enCnt[4];
   int clrCnt[4];
   int prevPass[2];

   always #5 clk = ~clk;

   stream_mac_ctrl u_dutA (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .start_i      (startA),
      .num_pass_i   (numPassA),
      .stall_i      (stallA),
      .local_en_o   (enA),
      .clear_local_o(clrA),
      .pass_idx_o   (passA),
      .busy_o       (busyA),
      .done_o       (doneA)
   );

   stream_mac_ctrl #(
      .NUM_LANE(4),
      .MAC_LEN (4),
      .SKEW    (2),
      .PASS_W  (8)
   ) u_dutB (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .start_i      (startB),
      .num_pass_i   (numPassB),
      .stall_i      (stallB),
      .local_en_o   (enB),
      .clear_local_o(clrB),
      .pass_idx_o   (passB),
      .busy_o       (busyB),
      .done_o       (doneB)
   );

   // Counts one comparison and reports it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives the selected instance; the other one is kept idle.
   task automatic applyStimulus(input int sel, input logic start, input logic [7:0] np,
                                input logic stall);
      startA = 1'b0; stallA = 1'b0; numPassA = '0;
      startB = 1'b0; stallB = 1'b0; numPassB = '0;
      if (sel == 0) begin
         startA = start; stallA = stall; numPassA = np;
      end else begin
         startB = start; stallB = stall; numPassB = np;
      end
   endtask

   // Lane-local schedule at time t for P passes of length L: {en, clr}.
   function automatic logic [1:0] laneModel(input int L, input int P, input int t);
      if (t < 1 || t > P * (L + 1)) return 2'b00;
      if (t % (L + 1) == 0) return 2'b01;
      return 2'b10;
   endfunction

   // Compares every output of one instance against the model for one cycle.
   task automatic checkCycle(input int sel, input int c, input bit active, input int tau,
                             input int P, input bit stall);
      int N, L, S, tDone, pidx;
      logic [1:0]  b;
      logic [31:0] expEn, expClr, expPass, expBusy, expDone;
      logic [31:0] obsEn, obsClr, obsPass, obsBusy, obsDone;
      N = (sel == 0) ? 2 : 4;
      L = (sel == 0) ? 53 : 4;
      S = (sel == 0) ? 0 : 2;
      tDone = P * (L + 1) + (N - 1) * S + 1;
      expEn = '0; expClr = '0; expBusy = '0; expDone = '0;
      expPass = 32'(prevPass[sel]);
      if (active) begin
         expBusy = 32'd1;
         expDone = (tau == tDone) ? 32'd1 : 32'd0;
         pidx = (tau - 1) / (L + 1);
         expPass = 32'((pidx > P) ? P : pidx);
         for (int k = 0; k < N; k++) begin
            b = laneModel(L, P, tau - k * S);
            if (!stall) begin
               expEn[k]  = b[1];
               expClr[k] = b[0];
            end
         end
      end
      obsEn = '0; obsClr = '0;
      if (sel == 0) begin
         obsEn[1:0] = enA; obsClr[1:0] = clrA;
         obsPass = 32'(passA); obsBusy = 32'(busyA); obsDone = 32'(doneA);
      end else begin
         obsEn[3:0] = enB; obsClr[3:0] = clrB;
         obsPass = 32'(passB); obsBusy = 32'(busyB); obsDone = 32'(doneB);
      end
      checkOutput($sformatf("dut%0d.en@c%0d", sel, c), obsEn, expEn);
      checkOutput($sformatf("dut%0d.clr@c%0d", sel, c), obsClr, expClr);
      checkOutput($sformatf("dut%0d.en_clr_excl@c%0d", sel, c), obsEn & obsClr, 32'd0);
      checkOutput($sformatf("dut%0d.pass_idx@c%0d", sel, c), obsPass, expPass);
      checkOutput($sformatf("dut%0d.busy@c%0d", sel, c), obsBusy, expBusy);
      checkOutput($sformatf("dut%0d.done@c%0d", sel, c), obsDone, expDone);
      for (int k = 0; k < 4; k++) begin
         enCnt[k]  += int'(obsEn[k]);
         clrCnt[k] += int'(obsClr[k]);
      end
   endtask

   // One complete run from the start cycle (cycle 0) through the done cycle.
   // stallMode: 0 none, 1 stall in cycles 3..5, 2 random stall.
   task automatic runScenario(input int sel, input int numPass, input int stallMode,
                              input bit holdStart);
      int N, L, S, P, tDone, tau;
      bit reached, st;
      N = (sel == 0) ? 2 : 4;
      L = (sel == 0) ? 53 : 4;
      S = (sel == 0) ? 0 : 2;
      P = (numPass == 0) ? 1 : numPass;
      tDone = P * (L + 1) + (N - 1) * S + 1;
      tau = 1;
      reached = 1'b0;
      for (int k = 0; k < 4; k++) begin
         enCnt[k] = 0;
         clrCnt[k] = 0;
      end
      for (int c = 0; c < 4 * tDone + 20 && !reached; c++) begin
         @(posedge clk);
         #1;
         if (stallMode == 1) st = (c >= 3 && c <= 5);
         else if (stallMode == 2) st = ($urandom_range(0, 3) == 0);
         else st = 1'b0;
         applyStimulus(sel, (c == 0) || holdStart, 8'(numPass), st);
         @(negedge clk);
         if (c == 0) begin
            checkCycle(sel, c, 1'b0, 0, P, st);
         end else begin
            checkCycle(sel, c, 1'b1, tau, P, st);
            if (tau == tDone) reached = 1'b1;
            else if (!st) tau++;
         end
      end
      if (!reached) checkOutput($sformatf("dut%0d.run_timeout", sel), 32'd0, 32'd1);
      prevPass[sel] = P;
   endtask

   initial begin
      int np;
      prevPass[0] = 0;
      prevPass[1] = 0;
      rstn = 1'b0;
      applyStimulus(0, 1'b0, 8'd0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkCycle(0, 0, 1'b0, 0, 1, 1'b0);
      checkCycle(1, 0, 1'b0, 0, 1, 1'b0);
      @(posedge clk);
      #3 rstn = 1'b1;

      $display("[TB] defaults, one pass");
      runScenario(0, 1, 0, 1'b0);

      $display("[TB] 4 lanes skew 2, two passes");
      runScenario(1, 2, 0, 1'b0);

      $display("[TB] 4 lanes, two passes, stall cycles 3..5");
      runScenario(1, 2, 1, 1'b0);

      $display("[TB] 4 lanes, zero pass count");
      runScenario(1, 0, 0, 1'b0);

      $display("[TB] defaults, three passes, random stall");
      runScenario(0, 3, 2, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("dut0.en_count[%0d]", k), 32'(enCnt[k]), 32'(53 * 3));
         checkOutput($sformatf("dut0.clr_count[%0d]", k), 32'(clrCnt[k]), 32'd3);
      end

      $display("[TB] 4 lanes, random pass counts, random stall");
      for (int i = 0; i < 4; i++) begin
         np = int'($urandom_range(0, 4));
         runScenario(1, np, 2, 1'b0);
         for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("dut1.en_count[%0d]", k), 32'(enCnt[k]),
                        32'(4 * ((np == 0) ? 1 : np)));
            checkOutput($sformatf("dut1.clr_count[%0d]", k), 32'(clrCnt[k]),
                        32'((np == 0) ? 1 : np));
         end
      end

      $display("[TB] start held high, restart after done, then reset mid-run");
      runScenario(1, 1, 0, 1'b1);
      @(posedge clk);
      #1 applyStimulus(1, 1'b1, 8'd1, 1'b0);
      @(negedge clk);
      checkCycle(1, 0, 1'b0, 0, 1, 1'b0);
      @(posedge clk);
      #1 applyStimulus(1, 1'b1, 8'd1, 1'b0);
      @(negedge clk);
      checkCycle(1, 1, 1'b1, 1, 1, 1'b0);
      @(posedge clk);
      #1 applyStimulus(1, 1'b0, 8'd1, 1'b0);
      @(negedge clk);
      checkCycle(1, 2, 1'b1, 2, 1, 1'b0);
      @(posedge clk);
      #3 rstn = 1'b0;
      prevPass[0] = 0;
      prevPass[1] = 0;
      #1;
      checkCycle(1, 0, 1'b0, 0, 1, 1'b0);
      checkCycle(0, 0, 1'b0, 0, 1, 1'b0);
      @(posedge clk);
      #3 rstn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkCycle(1, c, 1'b0, 0, 1, 1'b0);
      end

      $display("[TB] full run after reset abort");
      runScenario(1, 2, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
